// File: rtl/sensor_distancia_ultrasonico.sv
// sensor_distancia_ultrasonico
// Ultrasonic range-finder front end (HC-SR04 class). Fires a periodic trigger
// pulse, times the synchronised echo pulse and converts its width to whole
// centimetres with an incremental sub-counter (no divider). The result is held
// on distancia until the next measurement completes.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   echo        in   sensor echo, asynchronous to clk
//   trig        out  sensor trigger, registered
//   distancia   out  [8:0] last distance in cm, 511 = no valid target
//   dato_valido out  one-cycle pulse when distancia/sin_eco update
//   sin_eco     out  1 = last measurement timed out
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | after reset, waiting for period counter = 0
// S_TRIG     | trig high for TRIG_CYCLES cycles
// S_WAIT_RISE| waiting for an echo rising edge, timeout running
// S_MEASURE  | echo high, counting centimetres, timeout running
// S_DONE     | result published, waiting for next period start
module sensor_distancia_ultrasonico #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int PERIOD_CYCLES  = 3_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] distancia,
    output logic       dato_valido,
    output logic       sin_eco
);

    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int TRG_W = $clog2(TRIG_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SUB_W = $clog2(CYCLES_PER_CM + 1);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_CM - 1);

    localparam logic [8:0] CM_MAX = 9'd511;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic             sync1;
    logic             echo_s;
    logic             echo_d;
    logic             rise;
    logic             fall;
    logic [2:0]       state;
    logic [PER_W-1:0] per_cnt;
    logic [TRG_W-1:0] trg_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic [8:0]       cm_cnt;
    logic [8:0]       cm_next;
    logic             sub_wrap;
    logic             tmo_hit;

    assign rise     = echo_s & ~echo_d;
    assign fall     = ~echo_s & echo_d;
    assign sub_wrap = (sub_cnt == SUB_LAST);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    // The cycle in which the fall is seen still counts as an echo-high cycle,
    // so the published value includes this cycle's increment.
    assign cm_next = (sub_wrap && cm_cnt != CM_MAX) ? cm_cnt + 9'd1 : cm_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            echo_s      <= 1'b0;
            echo_d      <= 1'b0;
            state       <= S_IDLE;
            per_cnt     <= '0;
            trg_cnt     <= '0;
            tmo_cnt     <= '0;
            sub_cnt     <= '0;
            cm_cnt      <= '0;
            trig        <= 1'b0;
            distancia   <= CM_MAX;
            dato_valido <= 1'b0;
            sin_eco     <= 1'b0;
        end else begin
            sync1       <= echo;
            echo_s      <= sync1;
            echo_d      <= echo_s;
            per_cnt     <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
            dato_valido <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (per_cnt == '0) begin
                        state   <= S_TRIG;
                        trig    <= 1'b1;
                        trg_cnt <= TRG_LAST;
                    end
                end
                S_TRIG: begin
                    if (trg_cnt == '0) begin
                        trig    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_WAIT_RISE;
                    end else begin
                        trg_cnt <= trg_cnt - 1'b1;
                    end
                end
                S_WAIT_RISE: begin
                    if (tmo_hit) begin
                        distancia   <= CM_MAX;
                        sin_eco     <= 1'b1;
                        dato_valido <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (rise) begin
                            sub_cnt <= '0;
                            cm_cnt  <= '0;
                            state   <= S_MEASURE;
                        end
                    end
                end
                S_MEASURE: begin
                    // fall has priority over a simultaneous timeout
                    if (fall) begin
                        distancia   <= cm_next;
                        sin_eco     <= 1'b0;
                        dato_valido <= 1'b1;
                        state       <= S_DONE;
                    end else if (tmo_hit) begin
                        distancia   <= CM_MAX;
                        sin_eco     <= 1'b1;
                        dato_valido <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
                        cm_cnt  <= cm_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
